// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with valid/ready on both sides and a one-word hold stage.
// Define SIPO_PARITY_EN to append an even-parity bit to each frame and report mismatches on par_err.
module sipo_deserializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ser_in,
   input  logic             ser_valid,
   output logic             ser_ready,
   output logic [WIDTH-1:0] par_data,
   output logic             par_valid,
   input  logic             par_ready,
   output logic             par_err
);

`ifdef SIPO_PARITY_EN
   localparam int FL = WIDTH + 1;
`else
   localparam int FL = WIDTH;
`endif
   localparam int CW = $clog2(FL + 1);
   localparam logic [CW-1:0] LAST = CW'(FL - 1);

   typedef enum logic {SHIFT, HOLD} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shift_nxt;
   logic [WIDTH-1:0] word;
   logic             accept;
   logic             last;
   logic             slot_free;
   logic             data_bit;

   assign ser_ready = (state == SHIFT);
   assign accept    = ser_valid && ser_ready;
   assign last      = (cnt == LAST);
   assign slot_free = !par_valid || par_ready;

   always_comb begin
      if (MSB_FIRST) shift_nxt = {shreg[WIDTH-2:0], ser_in};
      else           shift_nxt = {ser_in, shreg[WIDTH-1:1]};
   end

`ifdef SIPO_PARITY_EN
   logic acc;
   logic hold_err;
   logic err_q;
   logic err_nxt;

   // Last bit of a frame is parity, so the data word is already complete in shreg.
   assign data_bit = !last;
   assign word     = shreg;
   assign err_nxt  = acc ^ ser_in;
   assign par_err  = err_q;
`else
   assign data_bit = 1'b1;
   assign word     = shift_nxt;
   assign par_err  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SHIFT;
         cnt       <= '0;
         shreg     <= '0;
         par_data  <= '0;
         par_valid <= 1'b0;
`ifdef SIPO_PARITY_EN
         acc       <= 1'b0;
         hold_err  <= 1'b0;
         err_q     <= 1'b0;
`endif
      end else begin
         // Default drop on consume; a same-edge load below overrides it.
         if (par_valid && par_ready) par_valid <= 1'b0;

         if (state == SHIFT) begin
            if (accept) begin
               if (data_bit) shreg <= shift_nxt;
`ifdef SIPO_PARITY_EN
               acc <= last ? 1'b0 : (acc ^ ser_in);
`endif
               if (last) begin
                  cnt <= '0;
                  if (slot_free) begin
                     par_data  <= word;
                     par_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
                     err_q     <= err_nxt;
`endif
                  end else begin
                     state <= HOLD;
`ifdef SIPO_PARITY_EN
                     hold_err <= err_nxt;
`endif
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
         end else begin
            if (slot_free) begin
               par_data  <= shreg;
               par_valid <= 1'b1;
               state     <= SHIFT;
`ifdef SIPO_PARITY_EN
               err_q     <= hold_err;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed plus randomized bench for sipo_deserializer; MSB-first and LSB-first instances share stimulus.
module tb_sipo_deserializer;
   localparam int W = 4;
`ifdef SIPO_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic clk = 1'b0;
   logic rst, ser_in, ser_valid, par_ready;
   logic ser_ready, par_valid, par_err;
   logic [W-1:0] par_data;
   logic ser_ready_l, par_valid_l, par_err_l;
   logic [W-1:0] par_data_l;

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .ser_ready(ser_ready),
      .par_data(par_data), .par_valid(par_valid), .par_ready(par_ready), .par_err(par_err));

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .ser_ready(ser_ready_l),
      .par_data(par_data_l), .par_valid(par_valid_l), .par_ready(par_ready), .par_err(par_err_l));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: frames stored as received bits, f[0] = first bit; queue holds undelivered frames.
   logic [FL-1:0] q[$];
   logic [FL-1:0] frame;
   int            nbits;
   logic [FL-1:0] last_f;

   function automatic logic [W-1:0] msb_word(input logic [FL-1:0] f);
      logic [W-1:0] w;
      for (int i = 0; i < W; i++) w[W-1-i] = f[i];
      return w;
   endfunction

   function automatic logic [W-1:0] lsb_word(input logic [FL-1:0] f);
      logic [W-1:0] w;
      for (int i = 0; i < W; i++) w[i] = f[i];
      return w;
   endfunction

   function automatic logic exp_err(input logic [FL-1:0] f);
`ifdef SIPO_PARITY_EN
      return ^f;
`else
      return 1'b0 & f[0];
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs;
      logic [FL-1:0] f;
      f = (q.size() > 0) ? q[0] : last_f;
      chk("ser_ready", ser_ready, 32'(q.size() < 2));
      chk("ser_ready_lsb", ser_ready_l, 32'(q.size() < 2));
      chk("par_valid", par_valid, 32'(q.size() > 0));
      chk("par_valid_lsb", par_valid_l, 32'(q.size() > 0));
      chk("par_data_msb", par_data, 32'(msb_word(f)));
      chk("par_data_lsb", par_data_l, 32'(lsb_word(f)));
      if (q.size() > 0) begin
         chk("par_err", par_err, 32'(exp_err(f)));
         chk("par_err_lsb", par_err_l, 32'(exp_err(f)));
      end
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic step(input logic v, input logic b, input logic pr);
      logic acc, tk;
      ser_valid = v; ser_in = b; par_ready = pr;
      acc = v && (q.size() < 2);
      tk  = pr && (q.size() > 0);
      @(posedge clk); #1;
      if (tk) last_f = q.pop_front();
      if (acc) begin
         frame[nbits] = b;
         nbits++;
         if (nbits == FL) begin
            q.push_back(frame);
            if (!tk && q.size() == 1) last_f = frame;
            nbits = 0;
            frame = '0;
         end
      end
      // par_data reflects the newest loaded word even when par_valid is low.
      if (q.size() > 0) last_f = q[0];
      check_outputs();
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [W-1:0] bits, input logic pb, input logic pr);
      for (int i = W - 1; i >= 0; i--) step(1'b1, bits[i], pr);
`ifdef SIPO_PARITY_EN
      step(1'b1, pb, pr);
`else
      if (pb) ;
`endif
   endtask

   task automatic mid_reset;
      ser_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_par_valid", par_valid, 32'd0);
      chk("rst_par_data", par_data, 32'd0);
      chk("rst_ser_ready", ser_ready, 32'd1);
      chk("rst_par_err", par_err, 32'd0);
      q.delete(); nbits = 0; frame = '0; last_f = '0;
      #1 rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; par_ready = 1'b0;
      nbits = 0; frame = '0; last_f = '0;
      #12;
      check_outputs();
      rst = 1'b0;
      @(negedge clk);

      // 1: MSB-first 1010, one-cycle valid
      send_frame(4'b1010, 1'b0, 1'b1);
      chk("t1_word", par_data, 32'hA);
      step(1'b0, 1'b0, 1'b1);

      // 2: gaps between bits 2 and 3
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
`ifdef SIPO_PARITY_EN
      step(1'b1, 1'b1, 1'b1);
`endif
      chk("t2_lsb_word", par_data_l, 32'hB);
      step(1'b0, 1'b0, 1'b1);

      // 3: backpressure into HOLD, then release
      send_frame(4'b1011, 1'b1, 1'b0);
      send_frame(4'b1110, 1'b1, 1'b0);
      chk("t3_hold_ready", ser_ready, 32'd0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("t3_stable", par_data, 32'hB);
      step(1'b0, 1'b0, 1'b1);
      chk("t3_next", par_data, 32'hE);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);

      // 4: back-to-back frames
      send_frame(4'b1111, 1'b0, 1'b1);
      send_frame(4'b0001, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1);

      // 5: asynchronous reset mid-frame
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      mid_reset();
      send_frame(4'b0110, 1'b0, 1'b1);
      chk("t5_word", par_data, 32'h6);
      step(1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
      // 6: parity good then bad
      send_frame(4'b1011, 1'b1, 1'b1);
      chk("t6_err0", par_err, 32'd0);
      send_frame(4'b1011, 1'b0, 1'b1);
      chk("t6_err1", par_err, 32'd1);
      step(1'b0, 1'b0, 1'b1);
`endif

      // Randomized traffic with random gaps and backpressure
      for (int k = 0; k < 400; k++)
         step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0);
      for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
